mesm6_alu_seq: RTL and testbench
================================

// Module: mesm6_alu_seq
// PURPOSE
//  Parametrised multi-cycle integer ALU with a start/busy/done handshake, the
//  next generation of the mesm6 execution ALU. Word width is a parameter, an
//  iterative unsigned multiplier is added, and operands are latched at start.
//  Sits between the mesm6 control unit (accumulator A, operand B, Y register)
//  and the register file; the control unit issues one op and waits for done.
// PARAMETERS
//  W         48  data word width; W >= 8, W % MUL_BITS == 0
//  MUL_BITS   1  multiplier bits retired per cycle: 1, 2 or 4
//  SHW        6  shift-count field width; 2**SHW >= W
// PORTS
//  clk      in   1   clock, all state updates on posedge
//  reset    in   1   synchronous, active-high reset
//  start    in   1   issue op; sampled only while busy==0
//  op       in   4   0 AND,1 OR,2 XOR,3 ADD_CARRY_AROUND,4 COUNT,5 CLZ,6 SHIFT,
//                    7 PACK,8 UNPACK,9 MUL,10-15 illegal
//  a        in   W   operand A (accumulator)
//  b        in   W   operand B
//  busy     out  1   op in progress
//  done     out  1   one-cycle pulse: result/y/illegal valid
//  result   out  W   primary result
//  y        out  W   secondary (low-order / shifted-out) result
//  illegal  out  1   last op code was 10-15
// BEHAVIOUR
//  - Reset: busy=0, done=0, result=0, y=0, illegal=0, FSM=IDLE; reset during
//    any state aborts the op, no done pulse is produced.
//  - FSM: IDLE -start-> EXEC -(last step)-> IDLE with done=1 on exit edge.
//    start with busy=1 is ignored; a, b, op are latched at start, later
//    changes have no effect. start on the cycle done=1 (busy=0) is accepted.
//  - Latency L = cycles from start edge to done high: AND/OR/XOR/SHIFT/PACK/
//    UNPACK/illegal = 1; ADD/COUNT/CLZ = 2; MUL = 1 + W/MUL_BITS.
//    busy high from cycle after start through cycle before done.
//  - result, y, illegal hold their values after done until the next done.
//  - AND/OR: result=a&b / a|b, y=0.  XOR: result=a^b, y=a.
//  - ADD: {c,s}=a+b (W+1 bits); step 2 result=s+c (end-around, no carry out), y=0.
//  - COUNT: as ADD with adder input popcount(a) instead of a.
//  - CLZ: n = (a==0) ? 0 : (leading zeros of a)+1; as ADD with n; y=a<<n (truncated to W).
//  - SHIFT: k=b[W-2 -: SHW]. b[W-1]=1: {result,y}={a,0}>>k (right).
//    b[W-1]=0: {y,result}={0,a}<<(2**SHW-k) (left); k=0 means no shift.
//  - PACK: bits of a at set positions of b, taken LSB first, are shifted in
//    at result MSB (popcount(b) bits fill result top down). y=0.
//  - UNPACK: walking b from MSB down, each set bit i takes next a bit from
//    a[W-1] downward into result[i]; other result bits 0. y=0.
//  - MUL: unsigned a*b, 2W-bit product; result=high W bits, y=low W bits.
//    Shift-add, MUL_BITS multiplier bits per cycle, no early termination.
//  - Illegal op: result=0, y=0, illegal=1; legal ops clear illegal at done.
// TESTING (W=48, MUL_BITS=1 unless noted)
//  - ADD a=48'hFFFF_FFFF_FFFF, b=1 -> done 2 cycles after start,
//    result=48'h1, y=0.
//  - CLZ a=48'h0F00_0000_0000, b=0 -> result=5, y=48'hE000_0000_0000;
//    a=0 -> result=0, y=0.
//  - MUL a=b=48'h1_0000_0000 -> done at start+49, result=48'h1_0000, y=0;
//    repeat MUL_BITS=4 -> done at start+13, same values.
//  - PACK a=48'hFFFF_FFFF_FFFF, b=48'hFF -> result=48'hFF00_0000_0000;
//    UNPACK a=48'hA000_0000_0000, b=48'hF -> result=48'hA.
//  - start pulsed while busy during MUL, a/b changed -> ignored, original
//    product returned; back-to-back start on done cycle accepted.
//  - reset asserted at start+10 of MUL -> next cycle busy=0, done=0,
//    result=0, y=0; op=12 -> done at start+1, illegal=1, result=0.

Source files
------------

// File: rtl/mesm6_alu_seq_if.sv
// Issue/complete handshake between the mesm6 control unit and the sequential ALU.
interface mesm6_alu_seq_if #(parameter int W = 48);
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] y;
  logic         illegal;

  modport master (output start, op, a, b, input busy, done, result, y, illegal);
  modport slave  (input start, op, a, b, output busy, done, result, y, illegal);
endinterface

// File: rtl/mesm6_alu_seq.sv
// Multi-cycle mesm6 integer ALU: operands latched at start, one op in flight,
// done pulses for one cycle when result/y/illegal are updated.
module mesm6_alu_seq #(
  parameter int W        = 48,
  parameter int MUL_BITS = 1,
  parameter int SHW      = 6
) (
  input  logic           clk,
  input  logic           reset,
  mesm6_alu_seq_if.slave bus
);
  localparam int NSTEP = W / MUL_BITS;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam logic [CW-1:0] LAST_MUL = CW'(NSTEP);
  localparam logic [CW-1:0] LAST_ADD = CW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  localparam logic [3:0] OP_AND    = 4'd0;
  localparam logic [3:0] OP_OR     = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_COUNT  = 4'd4;
  localparam logic [3:0] OP_CLZ    = 4'd5;
  localparam logic [3:0] OP_SHIFT  = 4'd6;
  localparam logic [3:0] OP_PACK   = 4'd7;
  localparam logic [3:0] OP_UNPACK = 4'd8;
  localparam logic [3:0] OP_MUL    = 4'd9;

  logic [0:0]    state;
  logic [3:0]    op_r;
  logic [W-1:0]  a_r, b_r;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hi, lo;
  logic          cy;
  logic          busy, done, illegal;
  logic [W-1:0]  result, y;

  logic [W-1:0]          pop, clz_n, clz_y, pk, upk, src;
  logic [W-1:0]          add_x, add_s;
  logic                  add_c;
  logic [SHW-1:0]        k;
  logic [SHW:0]          lsh;
  logic [2*W-1:0]        rwide, lwide;
  logic [W+MUL_BITS-1:0] mul_sum;
  logic [W-1:0]          res_n, y_n;
  logic                  ill_n, last;

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.result  = result;
  assign bus.y       = y;
  assign bus.illegal = illegal;

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + W'(a_r[i]);
  end

  // Highest set bit wins; n counts leading zeros plus one.
  always_comb begin
    clz_n = '0;
    for (int i = 0; i < W; i++) if (a_r[i]) clz_n = W'(W - i);
  end
  assign clz_y = a_r << clz_n;

  always_comb begin
    pk = '0;
    for (int i = 0; i < W; i++) if (b_r[i]) pk = {a_r[i], pk[W-1:1]};
  end

  always_comb begin
    upk = '0;
    src = a_r;
    for (int i = W - 1; i >= 0; i--) begin
      if (b_r[i]) begin
        upk[i] = src[W-1];
        src    = src << 1;
      end
    end
  end

  // Left shift amount is the complement of k within the 2**SHW field range.
  assign k     = b_r[W-2 -: SHW];
  assign lsh   = (k == '0) ? '0 : (SHW+1)'(2**SHW) - (SHW+1)'(k);
  assign rwide = {a_r, {W{1'b0}}} >> k;
  assign lwide = {{W{1'b0}}, a_r} << lsh;

  assign add_x = (op_r == OP_COUNT) ? pop : (op_r == OP_CLZ) ? clz_n : a_r;
  assign {add_c, add_s} = {1'b0, add_x} + {1'b0, b_r};

  assign mul_sum = (W+MUL_BITS)'(hi)
                 + (W+MUL_BITS)'(a_r) * (W+MUL_BITS)'(lo[MUL_BITS-1:0]);

  always_comb begin
    last = 1'b1;
    if (op_r == OP_MUL) last = (cnt == LAST_MUL);
    else if (op_r == OP_ADD || op_r == OP_COUNT || op_r == OP_CLZ) last = (cnt == LAST_ADD);
  end

  always_comb begin
    res_n = '0;
    y_n   = '0;
    ill_n = 1'b0;
    case (op_r)
      OP_AND:    res_n = a_r & b_r;
      OP_OR:     res_n = a_r | b_r;
      OP_XOR:    begin res_n = a_r ^ b_r; y_n = a_r; end
      OP_ADD,
      OP_COUNT:  res_n = hi + W'(cy);
      OP_CLZ:    begin res_n = hi + W'(cy); y_n = clz_y; end
      OP_SHIFT:  begin
        if (b_r[W-1]) begin res_n = rwide[2*W-1:W]; y_n = rwide[W-1:0]; end
        else          begin y_n = lwide[2*W-1:W];  res_n = lwide[W-1:0]; end
      end
      OP_PACK:   res_n = pk;
      OP_UNPACK: res_n = upk;
      OP_MUL:    begin res_n = hi; y_n = lo; end
      default:   ill_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      y       <= '0;
      illegal <= 1'b0;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      cy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          op_r  <= bus.op;
          a_r   <= bus.a;
          b_r   <= bus.b;
          hi    <= '0;
          lo    <= bus.b;
          cy    <= 1'b0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= EXEC;
        end
        default: begin
          if (last) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= res_n;
            y       <= y_n;
            illegal <= ill_n;
          end else begin
            cnt <= cnt + 1'b1;
            // Multiplier consumed LSB first out of lo; product bits shift in from hi.
            if (op_r == OP_MUL) {hi, lo} <= {mul_sum, lo[W-1:MUL_BITS]};
            else begin
              hi <= add_s;
              cy <= add_c;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mesm6_alu_seq.sv
// Directed plus randomized checks of mesm6_alu_seq against a behavioural model.
module tb_mesm6_alu_seq;
  localparam int W = 48;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel = 1;

  logic         start1 = 1'b0, start4 = 1'b0;
  logic [3:0]   op_i = '0;
  logic [W-1:0] a_i = '0, b_i = '0;

  mesm6_alu_seq_if #(.W(W)) bus1 ();
  mesm6_alu_seq_if #(.W(W)) bus4 ();

  assign bus1.start = start1;
  assign bus1.op    = op_i;
  assign bus1.a     = a_i;
  assign bus1.b     = b_i;
  assign bus4.start = start4;
  assign bus4.op    = op_i;
  assign bus4.a     = a_i;
  assign bus4.b     = b_i;

  mesm6_alu_seq #(.W(W), .MUL_BITS(1), .SHW(6)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  mesm6_alu_seq #(.W(W), .MUL_BITS(4), .SHW(6)) u4 (.clk(clk), .reset(reset), .bus(bus4));

  wire         o_busy = (sel == 4) ? bus4.busy    : bus1.busy;
  wire         o_done = (sel == 4) ? bus4.done    : bus1.done;
  wire         o_ill  = (sel == 4) ? bus4.illegal : bus1.illegal;
  wire [W-1:0] o_res  = (sel == 4) ? bus4.result  : bus1.result;
  wire [W-1:0] o_y    = (sel == 4) ? bus4.y       : bus1.y;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat);
    op_i = o; a_i = av; b_i = bv;
    if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    lat = 0;
    chk("busy_after_start", W'(o_busy), W'(1));
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (o_done) break;
    end
  endtask

  task automatic exp_op(input string tag, input int s, input logic [3:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv, input int el,
                        input logic [W-1:0] er, input logic [W-1:0] ey, input logic ei);
    int lat;
    sel = s;
    run_op(o, av, bv, lat);
    chk({tag, "_lat"}, W'(lat), W'(el));
    chk({tag, "_res"}, o_res, er);
    chk({tag, "_y"}, o_y, ey);
    chk({tag, "_ill"}, W'(o_ill), W'(ei));
  endtask

  function automatic void model(input logic [3:0] o, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input int mb,
                                output logic [W-1:0] r, output logic [W-1:0] yy,
                                output logic il, output int lat);
    logic [W:0]     t;
    logic [2*W-1:0] w2;
    logic [W-1:0]   v, x;
    int n, lz, k;
    r = '0; yy = '0; il = 1'b0; lat = 1;
    case (o)
      4'd0: r = av & bv;
      4'd1: r = av | bv;
      4'd2: begin r = av ^ bv; yy = av; end
      4'd3, 4'd4, 4'd5: begin
        lat = 2;
        x = av;
        if (o == 4'd4) x = W'($countones(av));
        if (o == 4'd5) begin
          v = av; lz = 0;
          while (lz < W && v[W-1] == 1'b0) begin v = v << 1; lz++; end
          n = (av == '0) ? 0 : lz + 1;
          x = W'(n);
          yy = av << n;
        end
        t = {1'b0, x} + {1'b0, bv};
        r = t[W-1:0] + W'(t[W]);
      end
      4'd6: begin
        k = int'(bv[W-2 -: 6]);
        if (bv[W-1]) begin
          w2 = {av, {W{1'b0}}} >> k;
          r = w2[2*W-1:W]; yy = w2[W-1:0];
        end else begin
          w2 = {{W{1'b0}}, av} << ((k == 0) ? 0 : 64 - k);
          yy = w2[2*W-1:W]; r = w2[W-1:0];
        end
      end
      4'd7: begin
        v = '0; n = 0;
        for (int i = 0; i < W; i++)
          if (bv[i]) begin v = v | (W'(av[i]) << n); n++; end
        r = (n == 0) ? '0 : v << (W - n);
      end
      4'd8: begin
        n = 0;
        for (int i = W - 1; i >= 0; i--)
          if (bv[i]) begin r = r | (((av >> (W - 1 - n)) & W'(1)) << i); n++; end
      end
      4'd9: begin
        w2 = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
        r = w2[2*W-1:W]; yy = w2[W-1:0];
        lat = 1 + W / mb;
      end
      default: il = 1'b1;
    endcase
  endfunction

  initial begin
    logic [W-1:0] er, ey, ra, rb;
    logic         ei;
    int           el, lat, ndone;
    logic [3:0]   ro;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(bus1.busy), W'(0));
    chk("rst_done", W'(bus1.done), W'(0));
    chk("rst_res", bus1.result, '0);
    chk("rst_y", bus1.y, '0);
    chk("rst_ill", W'(bus1.illegal), W'(0));
    chk("rst4_busy", W'(bus4.busy), W'(0));
    reset = 1'b0;

    // Each call starts on the previous done cycle, so issue-on-done is exercised throughout.
    exp_op("add_wrap", 1, 4'd3, 48'hFFFF_FFFF_FFFF, 48'h1, 2, 48'h1, '0, 1'b0);
    exp_op("clz", 1, 4'd5, 48'h0F00_0000_0000, '0, 2, 48'h5, 48'hE000_0000_0000, 1'b0);
    exp_op("clz_zero", 1, 4'd5, '0, '0, 2, '0, '0, 1'b0);
    exp_op("count", 1, 4'd4, 48'hFF, 48'hFFFF_FFFF_FFFA, 2, 48'h3, '0, 1'b0);
    exp_op("mul1", 1, 4'd9, 48'h1_0000_0000, 48'h1_0000_0000, 49, 48'h1_0000, '0, 1'b0);
    exp_op("mul4", 4, 4'd9, 48'h1_0000_0000, 48'h1_0000_0000, 13, 48'h1_0000, '0, 1'b0);
    exp_op("pack", 1, 4'd7, 48'hFFFF_FFFF_FFFF, 48'hFF, 1, 48'hFF00_0000_0000, '0, 1'b0);
    exp_op("unpack", 1, 4'd8, 48'hA000_0000_0000, 48'hF, 1, 48'hA, '0, 1'b0);
    exp_op("and", 1, 4'd0, 48'hF0F0, 48'h0FF0, 1, 48'h00F0, '0, 1'b0);
    exp_op("or", 1, 4'd1, 48'hF0F0, 48'h0FF0, 1, 48'hFFF0, '0, 1'b0);
    exp_op("xor", 1, 4'd2, 48'hF0F0, 48'h0FF0, 1, 48'hFF00, 48'hF0F0, 1'b0);
    exp_op("shr", 1, 4'd6, 48'hF3, {1'b1, 6'd4, 41'd0}, 1, 48'hF, 48'h3000_0000_0000, 1'b0);
    exp_op("shl", 1, 4'd6, 48'hF000_0000_0001, {1'b0, 6'd60, 41'd0}, 1, 48'h10, 48'hF, 1'b0);
    exp_op("shl_k0", 1, 4'd6, 48'h1234_5678_9ABC, '0, 1, 48'h1234_5678_9ABC, '0, 1'b0);

    // Start pulse and operand changes while busy must not disturb the running multiply.
    sel = 1;
    op_i = 4'd9; a_i = 48'h1_0000_0000; b_i = 48'h1_0000_0000; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin op_i = 4'd0; a_i = 48'h1234; b_i = 48'h5678; start1 = 1'b1; end
      if (lat == 6) start1 = 1'b0;
      if (o_done) break;
    end
    chk("ign_lat", W'(lat), W'(49));
    chk("ign_res", o_res, 48'h1_0000);
    chk("ign_y", o_y, '0);

    // Reset in the middle of a multiply aborts it with no done pulse.
    op_i = 4'd9; a_i = 48'h3; b_i = 48'h5; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", W'(o_busy), W'(0));
    chk("abort_done", W'(o_done), W'(0));
    chk("abort_res", o_res, '0);
    chk("abort_y", o_y, '0);
    reset = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_done) ndone++;
    end
    chk("abort_no_done", W'(ndone), W'(0));
    exp_op("illegal12", 1, 4'd12, 48'h5, 48'h7, 1, '0, '0, 1'b1);
    exp_op("legal_clears", 1, 4'd0, 48'h5, 48'h7, 1, 48'h5, '0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (ro == 4'd5) ra = ra >> $urandom_range(0, 47);
      if (ro == 4'd7 || ro == 4'd8) rb = rb >> $urandom_range(0, 40);
      sel = (ro == 4'd9 && (i % 2 == 1)) ? 4 : 1;
      model(ro, ra, rb, (sel == 4) ? 4 : 1, er, ey, ei, el);
      exp_op($sformatf("rnd%0d_op%0d", i, ro), sel, ro, ra, rb, el, er, ey, ei);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
